fp_sign_unit: RTL
=================

Name: fp_sign_unit

Overview:
- Parametrised, pipelined sign-manipulation unit for the floating-point co-processor. Generalises the fixed two-stage negation block.
- Supports four modes: pass, negate, absolute, negative-absolute.
- Configurable format widths and pipeline depth.
- Adds valid/ready backpressure, flush, NaN handling and zero/NaN flags.
- Sits between the operand dispatch and the register-file writeback arbiter. The destination address travels with the data.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, fraction field width. DATA_W = 1+EXP_W+FRAC_W is a derived localparam.
- ADDR_W, 4, destination register address width.
- STAGES, 2, pipeline depth. Legal range 1..4; illegal values fail elaboration.
- NAN_PRESERVE, 1, when 1 NaN inputs pass unmodified in every mode. When 0 the sign bit is manipulated as for any other value.

Ports:
- clk  in  1  clock, rising edge.
- nRst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  unit accepts the input this cycle.
- in_value  in  DATA_W  operand.
- in_mode  in  2  00 PASS, 01 NEG, 10 ABS, 11 NABS.
- in_dest_addr  in  ADDR_W  destination register tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- out_value  out  DATA_W  result.
- out_dest_addr  out  ADDR_W  tag carried with the result.
- out_nan  out  1  operand was NaN: exponent all ones, fraction nonzero.
- out_zero  out  1  operand was ±0: exponent and fraction both zero.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset: every stage valid bit, data, address and flag register is 0. Outputs are therefore all 0; in_ready is 1 once reset is released.
- Reset mid-operation discards all in-flight operations with no output.
- Transfer rule: an input is accepted on a clock edge where in_valid && in_ready. A result is consumed on an edge where out_valid && out_ready.
- Compute happens combinationally on the input, before the stage-0 register:
  - PASS: sign unchanged.
  - NEG: sign = ~sign.
  - ABS: sign = 0.
  - NABS: sign = 1.
  - Exponent and fraction are always copied unchanged.
  - If NAN_PRESERVE=1 and the input is NaN, the output equals the input.
  - Flags are computed from the input operand, not the result.
- Pipeline control:
  - Stage k holds valid_k plus its payload.
  - ready_k = !valid_k || ready_(k+1), with ready_STAGES = out_ready.
  - in_ready = ready_0, a combinational chain.
  - A stage loads its payload only when it advances. A stage that does not advance holds its payload bit-exactly.
  - out_* is driven from the last stage.
- Latency: exactly STAGES cycles from acceptance to out_valid when there are no stalls.
- Throughput: one operation per cycle while out_ready=1.
- Backpressure:
  - While out_valid && !out_ready, out_value, out_dest_addr and the flags are stable.
  - The pipe fills with up to STAGES operations, then in_ready=0.
  - No loss, no duplication, order preserved.
- Simultaneous events:
  - Accept and consume in the same cycle on a full pipe is allowed, because ready propagates, so the pipe stays full.
  - flush has priority over everything. On the next edge all valid bits clear, and an input presented in the flush cycle is dropped.
  - in_ready is driven 0 during flush.
- out_valid never depends combinationally on out_ready.

Decomposition:
- Package fp_sign_pkg holds:
  - the mode enum type (PASS/NEG/ABS/NABS, 2 bits);
  - the default EXP_W/FRAC_W constants;
  - the is_nan and is_zero functions, parametrised by field widths.
- Sub-module fp_sign_stage: one valid/ready register slot carrying {value, addr, nan, zero}, with flush.
  - Instantiated STAGES times via a generate loop.
  - The top level holds the compute logic and the ready chain.

Test Plan:
- STAGES=2, NEG on 0x40400000 (3.0), addr 5, out_ready=1 -> out_value 0xC0400000, addr 5, out_valid exactly 2 cycles after acceptance, flags 0.
- ABS on 0xC0400000 -> 0x40400000. NABS on 0x00000000 -> 0x80000000 with out_zero=1. PASS on 0x80000000 -> 0x80000000 with out_zero=1.
- NAN_PRESERVE=1, NEG on 0x7FC00001 -> 0x7FC00001, out_nan=1.
- Rerun with NAN_PRESERVE=0 -> 0xFFC00001, out_nan=1.
- Backpressure: 4 back-to-back inputs (NEG of 1.0, 2.0, 3.0, 4.0; addr 1-4) with out_ready=0 for 4 cycles:
  - in_ready drops after 2 are accepted;
  - outputs hold stable while stalled;
  - after release: 0xBF800000, 0xC0000000, 0xC0400000, 0xC0800000, in order, no gaps at full throughput.
- Flush with 2 operations in flight, plus in_valid=1 in the same cycle -> next cycle busy=0 and out_valid=0; no result emerges for any of the 3.
- nRst asserted mid-stream, asynchronously between edges -> outputs 0 immediately; after release in_ready=1 and no stale results appear.

Source files
------------

// File: rtl/fp_sign_pkg.sv
// rtl/fp_sign_pkg.sv - shared types, default widths and operand classification for the sign unit
package fp_sign_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_NEG  = 2'b01,
      MODE_ABS  = 2'b10,
      MODE_NABS = 2'b11
   } mode_e;

   localparam int DEF_EXP_W  = 8;
   localparam int DEF_FRAC_W = 23;

   // Fields arrive zero-extended to 64 bits; exp_w says how many exponent bits are real.
   function automatic logic is_nan(input logic [63:0] e, input logic [63:0] f,
                                   input int unsigned exp_w);
      logic [63:0] ones;
      ones = (64'd1 << exp_w) - 64'd1;
      return (e == ones) && (f != 64'd0);
   endfunction

   function automatic logic is_zero(input logic [63:0] e, input logic [63:0] f);
      return (e == 64'd0) && (f == 64'd0);
   endfunction

endpackage

// File: rtl/fp_sign_unit_if.sv
// rtl/fp_sign_unit_if.sv - operand/result handshake bundle between dispatch, sign unit and writeback
interface fp_sign_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) ();
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_value;
   logic [1:0]        in_mode;
   logic [ADDR_W-1:0] in_dest_addr;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_value;
   logic [ADDR_W-1:0] out_dest_addr;
   logic              out_nan;
   logic              out_zero;
   logic              busy;

   modport master (
      output flush, in_valid, in_value, in_mode, in_dest_addr, out_ready,
      input  in_ready, out_valid, out_value, out_dest_addr, out_nan, out_zero, busy
   );

   modport slave (
      input  flush, in_valid, in_value, in_mode, in_dest_addr, out_ready,
      output in_ready, out_valid, out_value, out_dest_addr, out_nan, out_zero, busy
   );
endinterface

// File: rtl/fp_sign_stage.sv
// rtl/fp_sign_stage.sv - one valid/ready register slot carrying value, tag and operand flags
module fp_sign_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              flush,
   input  logic              i_valid,
   input  logic              i_ready,
   input  logic [DATA_W-1:0] i_value,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_nan,
   input  logic              i_zero,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_value,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_nan,
   output logic              o_zero
);
   logic              r_valid;
   logic [DATA_W-1:0] r_value;
   logic [ADDR_W-1:0] r_addr;
   logic              r_nan;
   logic              r_zero;

   // Payload only moves when a real operation advances in, so a stalled slot stays bit-exact.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_valid <= 1'b0;
         r_value <= '0;
         r_addr  <= '0;
         r_nan   <= 1'b0;
         r_zero  <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (i_ready) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_value <= i_value;
            r_addr  <= i_addr;
            r_nan   <= i_nan;
            r_zero  <= i_zero;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_value = r_value;
   assign o_addr  = r_addr;
   assign o_nan   = r_nan;
   assign o_zero  = r_zero;
endmodule

// File: rtl/fp_sign_unit.sv
// rtl/fp_sign_unit.sv - pipelined pass/neg/abs/nabs sign unit with backpressure, flush and NaN/zero flags
module fp_sign_unit
   import fp_sign_pkg::*;
#(
   parameter int EXP_W        = DEF_EXP_W,
   parameter int FRAC_W       = DEF_FRAC_W,
   parameter int ADDR_W       = 4,
   parameter int STAGES       = 2,
   parameter bit NAN_PRESERVE = 1'b1
) (
   input  logic          clk,
   input  logic          nRst,
   fp_sign_unit_if.slave bus
);
   localparam int DATA_W = 1 + EXP_W + FRAC_W;

   generate
      if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
         $error("fp_sign_unit: STAGES must be within 1..4");
      end
   endgenerate

   logic              w_sign;
   logic              w_res_sign;
   logic [EXP_W-1:0]  w_exp;
   logic [FRAC_W-1:0] w_frac;
   logic              w_nan;
   logic              w_zero;
   mode_e             w_mode;

   assign {w_sign, w_exp, w_frac} = bus.in_value;
   assign w_mode = mode_e'(bus.in_mode);
   assign w_nan  = is_nan(64'(w_exp), 64'(w_frac), EXP_W);
   assign w_zero = is_zero(64'(w_exp), 64'(w_frac));

   always_comb begin
      w_res_sign = w_sign;
      case (w_mode)
         MODE_NEG:  w_res_sign = ~w_sign;
         MODE_ABS:  w_res_sign = 1'b0;
         MODE_NABS: w_res_sign = 1'b1;
         default:   w_res_sign = w_sign;
      endcase
      if (NAN_PRESERVE && w_nan) w_res_sign = w_sign;
   end

   // Index 0 is the computed input side; index k+1 is the output of stage k.
   logic [STAGES:0]             w_v;
   logic [STAGES:0][DATA_W-1:0] w_value;
   logic [STAGES:0][ADDR_W-1:0] w_addr;
   logic [STAGES:0]             w_nan_p;
   logic [STAGES:0]             w_zero_p;
   logic [STAGES-1:0]           w_ready;
   logic                        w_rdy_acc;

   assign w_v[0]      = bus.in_valid & ~bus.flush;
   assign w_value[0]  = {w_res_sign, w_exp, w_frac};
   assign w_addr[0]   = bus.in_dest_addr;
   assign w_nan_p[0]  = w_nan;
   assign w_zero_p[0] = w_zero;

   // Ready ripples back from the consumer; a stage is free if empty or its successor moves.
   always_comb begin
      w_rdy_acc = bus.out_ready;
      w_ready   = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_rdy_acc  = ~w_v[k+1] | w_rdy_acc;
         w_ready[k] = w_rdy_acc;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      fp_sign_stage #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_stage (
         .clk     (clk),
         .nRst    (nRst),
         .flush   (bus.flush),
         .i_valid (w_v[k]),
         .i_ready (w_ready[k]),
         .i_value (w_value[k]),
         .i_addr  (w_addr[k]),
         .i_nan   (w_nan_p[k]),
         .i_zero  (w_zero_p[k]),
         .o_valid (w_v[k+1]),
         .o_value (w_value[k+1]),
         .o_addr  (w_addr[k+1]),
         .o_nan   (w_nan_p[k+1]),
         .o_zero  (w_zero_p[k+1])
      );
   end

   assign bus.in_ready      = w_ready[0] & ~bus.flush;
   assign bus.out_valid     = w_v[STAGES];
   assign bus.out_value     = w_value[STAGES];
   assign bus.out_dest_addr = w_addr[STAGES];
   assign bus.out_nan       = w_nan_p[STAGES];
   assign bus.out_zero      = w_zero_p[STAGES];
   assign bus.busy          = |w_v[STAGES:1];
endmodule
